// File: rtl/td4_prog_loader.sv
// TD4 program loader: encodes mnemonic/immediate pairs into a 16x8 program memory and holds the core in reset until loading ends.
// Optional running checksum of written words when TD4_LOADER_CHECKSUM_EN is defined.
module td4_prog_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_mn,
  input  logic [3:0] in_imm,
  input  logic       in_last,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cpu_rst_n,
  output logic [4:0] wr_count,
  output logic       err,
  output logic [7:0] chk
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  addr_reg;
  logic [4:0]  wr_count_reg;
  logic        err_reg;
  logic [7:0]  mem [16];

  logic        legal;
  logic [3:0]  opcode;
  logic [3:0]  imm_enc;
  logic [7:0]  word;
  logic        hs;
  logic        wr_en;
  logic        sess_end;

  // Mnemonic decode; register-only forms carry a zero immediate.
  always_comb begin
    legal   = 1'b1;
    opcode  = in_mn;
    imm_enc = in_imm;
    case (in_mn)
      4'd0, 4'd3, 4'd5, 4'd7: ;
      4'd1, 4'd2, 4'd4, 4'd6: imm_enc = 4'h0;
      4'd8: begin
        opcode  = 4'b1001;
        imm_enc = 4'h0;
      end
      4'd9:  opcode = 4'b1011;
      4'd10: opcode = 4'b1110;
      4'd11: opcode = 4'b1111;
      default: begin
        legal  = 1'b0;
        opcode = 4'h0;
      end
    endcase
  end

  assign word      = {opcode, imm_enc};
  assign in_ready  = (state_reg == LOAD);
  assign cpu_rst_n = (state_reg == RUN);
  // A pair presented alongside start belongs to the abandoned session.
  assign hs        = in_valid & in_ready & ~start;
  assign wr_en     = hs & legal;
  assign sess_end  = hs & (in_last | (legal & (wr_count_reg == 5'd15)));

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = LOAD;
    end else if ((state_reg == LOAD) && sess_end) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= 4'h0;
      wr_count_reg <= 5'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        addr_reg     <= 4'h0;
        wr_count_reg <= 5'd0;
        err_reg      <= 1'b0;
      end else if (hs) begin
        if (legal) begin
          addr_reg     <= addr_reg + 4'd1;
          wr_count_reg <= wr_count_reg + 5'd1;
        end else begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  // Reset clears every word so an unloaded core executes ADD A,0 no-ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[addr_reg] <= word;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign wr_count = wr_count_reg;
  assign err      = err_reg;

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [7:0] chk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_reg <= 8'h00;
    end else if (start) begin
      chk_reg <= 8'h00;
    end else if (wr_en) begin
      chk_reg <= chk_reg + word;
    end
  end

  assign chk = chk_reg;
`else
  assign chk = 8'h00;
`endif

endmodule

// File: tb/tb_td4_prog_loader.sv
// Scoreboard bench for td4_prog_loader: stimulus queues expected observations, a monitor process samples and compares them.
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_mn;
  logic [3:0] in_imm;
  logic       in_last;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_rst_n;
  logic [4:0] wr_count;
  logic       err;
  logic [7:0] chk;

  td4_prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mn(in_mn), .in_imm(in_imm), .in_last(in_last), .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_rst_n(cpu_rst_n), .wr_count(wr_count), .err(err), .chk(chk)
  );

  always #5 clk = ~clk;

  localparam int K_MEM = 0, K_CNT = 1, K_ERR = 2, K_CPU = 3, K_RDY = 4, K_CHK = 5;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  bit    busy  = 0;

  function automatic logic [7:0] chk_of(input logic [7:0] v);
`ifdef TD4_LOADER_CHECKSUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  // Monitor: owns rd_addr, samples the DUT for each queued expectation.
  initial begin
    item_t it;
    logic [7:0] act;
    rd_addr = 4'h0;
    forever begin
      if (sb.size() == 0) begin
        #1;
      end else begin
        busy = 1;
        it = sb.pop_front();
        rd_addr = it.addr;
        #1;
        case (it.kind)
          K_MEM:   act = rd_data;
          K_CNT:   act = {3'b000, wr_count};
          K_ERR:   act = {7'b0, err};
          K_CPU:   act = {7'b0, cpu_rst_n};
          K_RDY:   act = {7'b0, in_ready};
          default: act = chk;
        endcase
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
        end else begin
          $display("ok   %s: %02h", it.name, act);
        end
        busy = 0;
      end
    end
  end

  task automatic expect_v(input int kind, input logic [3:0] addr, input logic [7:0] v, input string name);
    item_t it;
    it.kind = kind;
    it.addr = addr;
    it.exp  = v;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) #1;
    if (sb.size() != 0 || busy) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] mn, input logic [3:0] imm, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_mn    = mn;
    in_imm   = imm;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_mn = 4'h0; in_imm = 4'h0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_v(K_RDY, 0, 8'h00, "rst_ready");
    expect_v(K_CPU, 0, 8'h00, "rst_cpu");
    expect_v(K_CNT, 0, 8'h00, "rst_cnt");
    expect_v(K_ERR, 0, 8'h00, "rst_err");
    expect_v(K_CHK, 0, 8'h00, "rst_chk");
    expect_v(K_MEM, 4'd5, 8'h00, "rst_mem5");
    drain();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic session with mixed immediate/register forms
    do_start();
    expect_v(K_RDY, 0, 8'h01, "s1_ready");
    expect_v(K_CPU, 0, 8'h00, "s1_cpu_low");
    drain();
    send(4'd3, 4'd5, 1'b0);
    send(4'd0, 4'd1, 1'b0);
    send(4'd8, 4'd7, 1'b0);
    expect_v(K_CPU, 0, 8'h00, "s1_cpu_before_last");
    drain();
    send(4'd11, 4'd1, 1'b1);
    expect_v(K_CPU, 0, 8'h01, "s1_cpu_rise");
    expect_v(K_RDY, 0, 8'h00, "s1_ready_low");
    expect_v(K_MEM, 4'd0, 8'h35, "s1_mem0");
    expect_v(K_MEM, 4'd1, 8'h01, "s1_mem1");
    expect_v(K_MEM, 4'd2, 8'h90, "s1_mem2");
    expect_v(K_MEM, 4'd3, 8'hF1, "s1_mem3");
    expect_v(K_CNT, 0, 8'd4, "s1_cnt");
    expect_v(K_CHK, 0, chk_of(8'hB7), "s1_chk");
    drain();

    // Sixteen back-to-back writes end the session without in_last
    do_start();
    expect_v(K_CPU, 0, 8'h00, "s2_cpu_fall");
    expect_v(K_CNT, 0, 8'h00, "s2_cnt_clear");
    drain();
    for (int i = 0; i < 16; i++) send(4'd7, 4'(i), 1'b0);
    expect_v(K_CPU, 0, 8'h01, "s2_cpu_run");
    expect_v(K_CNT, 0, 8'd16, "s2_cnt16");
    expect_v(K_RDY, 0, 8'h00, "s2_ready_low");
    expect_v(K_CHK, 0, chk_of(8'h78), "s2_chk");
    for (int i = 0; i < 16; i++) expect_v(K_MEM, 4'(i), 8'h70 | 8'(i), $sformatf("s2_mem%0d", i));
    drain();

    // Illegal mnemonic is consumed without a write
    do_start();
    send(4'd13, 4'd2, 1'b0);
    send(4'd3, 4'd4, 1'b1);
    expect_v(K_ERR, 0, 8'h01, "s3_err");
    expect_v(K_MEM, 4'd0, 8'h34, "s3_mem0");
    expect_v(K_MEM, 4'd1, 8'h71, "s3_mem1_kept");
    expect_v(K_CNT, 0, 8'd1, "s3_cnt");
    expect_v(K_CPU, 0, 8'h01, "s3_cpu");
    expect_v(K_CHK, 0, chk_of(8'h34), "s3_chk");
    drain();

    // Restart from RUN with a single jump
    do_start();
    expect_v(K_CPU, 0, 8'h00, "s4_cpu_fall");
    expect_v(K_ERR, 0, 8'h00, "s4_err_clear");
    drain();
    send(4'd10, 4'd9, 1'b1);
    expect_v(K_MEM, 4'd0, 8'hE9, "s4_mem0");
    expect_v(K_MEM, 4'd1, 8'h71, "s4_mem1");
    expect_v(K_MEM, 4'd15, 8'h7F, "s4_mem15");
    expect_v(K_CNT, 0, 8'd1, "s4_cnt");
    expect_v(K_CPU, 0, 8'h01, "s4_cpu");
    drain();

    // Checksum pair
    do_start();
    send(4'd3, 4'd5, 1'b0);
    send(4'd11, 4'd1, 1'b1);
    expect_v(K_MEM, 4'd0, 8'h35, "s5_mem0");
    expect_v(K_MEM, 4'd1, 8'hF1, "s5_mem1");
    expect_v(K_CHK, 0, chk_of(8'h26), "s5_chk");
    drain();

    // Register-only forms zero the immediate
    do_start();
    send(4'd1, 4'hF, 1'b0);
    send(4'd2, 4'hF, 1'b0);
    send(4'd4, 4'hF, 1'b0);
    send(4'd6, 4'hF, 1'b0);
    send(4'd9, 4'hA, 1'b0);
    send(4'd5, 4'd3, 1'b1);
    expect_v(K_MEM, 4'd0, 8'h10, "s6_mem0");
    expect_v(K_MEM, 4'd1, 8'h20, "s6_mem1");
    expect_v(K_MEM, 4'd2, 8'h40, "s6_mem2");
    expect_v(K_MEM, 4'd3, 8'h60, "s6_mem3");
    expect_v(K_MEM, 4'd4, 8'hBA, "s6_mem4");
    expect_v(K_MEM, 4'd5, 8'h53, "s6_mem5");
    expect_v(K_CNT, 0, 8'd6, "s6_cnt");
    drain();

    // Restart inside LOAD; pair presented with start is dropped
    do_start();
    send(4'd3, 4'd1, 1'b0);
    expect_v(K_MEM, 4'd0, 8'h31, "s7_mem0_first");
    drain();
    start = 1'b1; in_valid = 1'b1; in_mn = 4'd3; in_imm = 4'd2; in_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    expect_v(K_CNT, 0, 8'd0, "s7_cnt_restart");
    expect_v(K_RDY, 0, 8'h01, "s7_still_load");
    expect_v(K_MEM, 4'd1, 8'h20, "s7_mem1_untouched");
    drain();
    send(4'd3, 4'd3, 1'b1);
    expect_v(K_MEM, 4'd0, 8'h33, "s7_mem0");
    expect_v(K_MEM, 4'd1, 8'h20, "s7_mem1");
    expect_v(K_CNT, 0, 8'd1, "s7_cnt");
    drain();

    // Reset mid-load clears everything including memory
    do_start();
    send(4'd7, 4'd1, 1'b0);
    send(4'd7, 4'd2, 1'b0);
    send(4'd7, 4'd3, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_v(K_CPU, 0, 8'h00, "s8_cpu");
    expect_v(K_CNT, 0, 8'd0, "s8_cnt");
    expect_v(K_RDY, 0, 8'h00, "s8_ready");
    expect_v(K_ERR, 0, 8'h00, "s8_err");
    expect_v(K_CHK, 0, 8'h00, "s8_chk");
    for (int i = 0; i < 16; i++) expect_v(K_MEM, 4'(i), 8'h00, $sformatf("s8_mem%0d", i));
    drain();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_v(K_MEM, 4'd0, 8'h00, "s8_mem0_after");
    expect_v(K_CPU, 0, 8'h00, "s8_cpu_idle");
    expect_v(K_RDY, 0, 8'h00, "s8_ready_idle");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
